// File: rtl/long_name_rr_arbiter_pkg.sv
// Shared types and width helpers for the long-name round-robin arbiter.
`timescale 1us/1us
package long_name_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Width of a counter that must hold values 0..max inclusive.
   function automatic int hold_w(input int max);
      return $clog2(max + 1);
   endfunction

   // Width of an index into a vector of n requesters.
   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/long_name_rr_arbiter_rr_pick.sv
// Combinational round-robin winner selection: rotate the request vector so the
// requester after last_owner sits at bit 0, take the lowest set bit, then map
// that offset back to an absolute requester index.
`timescale 1us/1us
module rr_pick
   import long_name_rr_arbiter_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]        req,
   input  logic [idx_w(N_REQ)-1:0] last_owner,
   output logic [idx_w(N_REQ)-1:0] winner,
   output logic                    any_req
);

   localparam int IDX_W = idx_w(N_REQ);

   typedef logic [IDX_W-1:0] idx_t;

   // Index addition modulo N_REQ; one extra bit keeps the carry for
   // requester counts that are not a power of two.
   function automatic idx_t add_mod(input idx_t a, input idx_t b);
      logic [IDX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IDX_W+1)'(N_REQ)) begin
         s = s - (IDX_W+1)'(N_REQ);
      end
      return s[IDX_W-1:0];
   endfunction

   idx_t             start;
   idx_t             offset;
   logic [N_REQ-1:0] rotated;
   logic             found;

   // Rotate, priority-encode from the lowest bit, unrotate.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      start   = add_mod(last_owner, idx_t'(1));
      rotated = '0;
      offset  = '0;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         rotated[i] = req[add_mod(start, idx_t'(i))];
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && rotated[i]) begin
            found  = 1'b1;
            offset = idx_t'(i);
         end
      end
      winner  = add_mod(start, offset);
      any_req = |req;
   end

endmodule

// File: rtl/long_name_rr_arbiter.sv
// Round-robin arbiter sharing one registered output bit among N_REQ requesters.
// An owner keeps the grant while it requests, up to MAX_HOLD cycles, and every
// release passes through at least one IDLE cycle with no grant.
`timescale 1us/1us
module long_name_rr_arbiter
   import long_name_rr_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ-1:0]              data,
   output logic [N_REQ-1:0]              grant,
   output logic                          o,
   output logic                          busy,
   output logic [hold_w(MAX_HOLD)-1:0]   hold_cnt
);

   localparam int IDX_W  = idx_w(N_REQ);
   localparam int HOLD_W = hold_w(MAX_HOLD);

   state_t             state_q;
   state_t             state_d;
   logic [N_REQ-1:0]   grant_d;
   logic [HOLD_W-1:0]  hold_d;
   logic               o_d;
   logic [IDX_W-1:0]   last_q;
   logic [IDX_W-1:0]   last_d;
   logic [IDX_W-1:0]   winner;
   logic               any_req;
   logic               release_now;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req        (req),
      .last_owner (last_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   // While in GRANT, last_q names the current owner.
   assign release_now = !req[last_q] || (hold_cnt == HOLD_W'(MAX_HOLD));
   assign busy        = (state_q == GRANT);

   // Next-state, next-grant, hold counter and output-bit decode.
   always_comb begin
      state_d = state_q;
      grant_d = '0;
      hold_d  = '0;
      o_d     = 1'b0;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = GRANT;
               grant_d = N_REQ'(1) << winner;
               hold_d  = HOLD_W'(1);
               last_d  = winner;
            end
         end
         GRANT: begin
            o_d = data[last_q];
            if (release_now) begin
               state_d = IDLE;
            end else begin
               grant_d = grant;
               hold_d  = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q  <= IDLE;
         grant    <= '0;
         o        <= 1'b0;
         hold_cnt <= '0;
         last_q   <= IDX_W'(N_REQ - 1);
      end else begin
         state_q  <= state_d;
         grant    <= grant_d;
         o        <= o_d;
         hold_cnt <= hold_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: tb/tb_long_name_rr_arbiter.sv
// Self-checking bench: directed phases with literal expectations, then a long
// randomized run compared every cycle against a behavioural owner/queue model.
`timescale 1us/1us
module tb_long_name_rr_arbiter;

   localparam int N     = 4;
   localparam int MAXH  = 8;
   localparam int HW    = $clog2(MAXH + 1);
   localparam int BOUND = (N - 1) * (MAXH + 1) + 1;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N-1:0]  data;
   logic [N-1:0]  grant;
   logic          o;
   logic          busy;
   logic [HW-1:0] hold_cnt;

   int n_checks = 0;
   int n_errors = 0;

   long_name_rr_arbiter #(
      .N_REQ    (N),
      .MAX_HOLD (MAXH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .data     (data),
      .grant    (grant),
      .o        (o),
      .busy     (busy),
      .hold_cnt (hold_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner = -1 means nobody holds the line.
   int   m_owner = -1;
   int   m_hold  = 0;
   int   m_last  = N - 1;
   logic m_o     = 1'b0;

   function automatic logic [N-1:0] m_grant();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1;
         m_hold  = 0;
         m_last  = N - 1;
         m_o     = 1'b0;
      end else if (m_owner < 0) begin
         automatic bit found = 0;
         m_o = 1'b0;
         for (int k = 1; k <= N; k++) begin
            automatic int idx = (m_last + k) % N;
            if (!found && req[idx]) begin
               found   = 1;
               m_owner = idx;
               m_hold  = 1;
               m_last  = idx;
            end
         end
      end else begin
         m_o = data[m_owner];
         if (!req[m_owner] || m_hold == MAXH) begin
            m_owner = -1;
            m_hold  = 0;
         end else begin
            m_hold = m_hold + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int wait_cnt [N];
   initial for (int i = 0; i < N; i++) wait_cnt[i] = 0;

   always @(negedge clk) begin
      check("grant", 32'(grant), 32'(m_grant()));
      check("o", 32'(o), 32'(m_o));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("hold_cnt", 32'(hold_cnt), 32'(m_hold));
      for (int i = 0; i < N; i++) begin
         if (!rst_n || !req[i] || grant[i]) wait_cnt[i] = 0;
         else wait_cnt[i] = wait_cnt[i] + 1;
         check("starvation bound", 32'(wait_cnt[i] <= BOUND), 32'd1);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      data  = '0;

      // Reset held 3 cycles with all requests high.
      repeat (3) begin
         @(negedge clk);
         check("rst grant", 32'(grant), 32'h0);
         check("rst o", 32'(o), 32'h0);
         check("rst busy", 32'(busy), 32'h0);
         check("rst hold", 32'(hold_cnt), 32'h0);
      end
      #1 rst_n = 1'b1;

      // Steady full request: 0,1,2,3,0 each for MAXH cycles, one gap between.
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < MAXH; c++) begin
            @(negedge clk);
            check("rr grant", 32'(grant), 32'(1 << (k % N)));
            check("rr model grant", 32'(m_grant()), 32'(1 << (k % N)));
            check("rr hold", 32'(hold_cnt), 32'(c + 1));
         end
         @(negedge clk);
         check("rr gap grant", 32'(grant), 32'h0);
         check("rr gap busy", 32'(busy), 32'h0);
      end

      // Early release and data path on index 2.
      #1 req = 4'b0100;
      @(negedge clk);
      check("dp grant", 32'(grant), 32'h4);
      check("dp hold1", 32'(hold_cnt), 32'd1);
      #1 data = 4'b0100;
      @(negedge clk);
      check("dp o1", 32'(o), 32'd1);
      check("dp hold2", 32'(hold_cnt), 32'd2);
      #1 data = 4'b0000;
      @(negedge clk);
      check("dp o0", 32'(o), 32'd0);
      #1 data = 4'b0100;
      @(negedge clk);
      check("dp o1b", 32'(o), 32'd1);
      check("dp hold4", 32'(hold_cnt), 32'd4);
      #1 begin req = 4'b0000; data = 4'b0000; end
      @(negedge clk);
      check("dp release grant", 32'(grant), 32'h0);
      check("dp release hold", 32'(hold_cnt), 32'h0);
      check("dp release busy", 32'(busy), 32'h0);
      @(negedge clk);
      check("dp idle o", 32'(o), 32'h0);

      // Sparse requests after last_owner = 3.
      #1 req = 4'b1000;
      @(negedge clk);
      check("sp pre grant", 32'(grant), 32'h8);
      #1 req = 4'b0000;
      @(negedge clk);
      check("sp pre release", 32'(grant), 32'h0);
      #1 req = 4'b1010;
      for (int c = 0; c < MAXH; c++) begin
         @(negedge clk);
         check("sp grant1", 32'(grant), 32'h2);
      end
      @(negedge clk);
      check("sp gap", 32'(grant), 32'h0);
      @(negedge clk);
      check("sp grant3", 32'(grant), 32'h8);
      #1 req = 4'b0000;
      @(negedge clk);
      check("sp release", 32'(grant), 32'h0);

      // Reset in the middle of a grant.
      #1 req = 4'b1111;
      @(negedge clk);
      check("mr grant0", 32'(grant), 32'h1);
      repeat (4) @(negedge clk);
      check("mr hold5", 32'(hold_cnt), 32'd5);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("mr abort grant", 32'(grant), 32'h0);
      check("mr abort o", 32'(o), 32'h0);
      check("mr abort busy", 32'(busy), 32'h0);
      check("mr abort hold", 32'(hold_cnt), 32'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mr regrant0", 32'(grant), 32'h1);

      // Randomized run: sticky requests, random data, rare resets.
      repeat (3000) begin
         #1;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         end
         data  = N'($urandom);
         rst_n = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/long_name_rr_arbiter.md
# long_name_rr_arbiter

Round-robin arbiter that shares one single-bit output line among `N_REQ` requesters. Each requester drives its data bit through the arbiter while granted. The block sits in front of the long-identifier pass-through design in the test environment. It gives the cocotb bench a sequential DUT with one-hot grants, hold counters and an FSM. Through it the bench exercises handle lookup, value logging and long log messages on a design that has real state. Simulation timescale is 1us/1us.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant; legal range ≥1.

Ports:
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req`  input  N_REQ  request per requester, level-sensitive.
- `data`  input  N_REQ  data bit per requester; sampled only for the current owner.
- `grant`  output  N_REQ  one-hot grant, registered; all zeros when no owner.
- `o`  output  1  shared line, registered; equals the owner's data bit delayed one cycle, 0 otherwise.
- `busy`  output  1  high while the FSM is in GRANT.
- `hold_cnt`  output  $clog2(MAX_HOLD+1)  number of cycles the current owner has held the grant.

## Operation
- FSM states: IDLE and GRANT.
- **IDLE**
  - If any `req` bit is high, pick the winner with the round-robin rule below.
  - Next cycle: `grant` becomes one-hot on the winner, the FSM enters GRANT, `hold_cnt` is 1 and `last_owner` is set to the winner.
  - If no `req` bit is high, stay in IDLE with `grant` = 0.
- **Round-robin rule**
  - Scan indices `last_owner+1`, `last_owner+2`, … modulo `N_REQ`; the first index with `req` high wins.
  - `last_owner` resets to `N_REQ-1`, so requester 0 has first priority after reset.
- **GRANT**
  - Each cycle, `o` takes the value of `data[owner]` sampled at that edge.
  - Release happens when `req[owner]` is low, or when `hold_cnt == MAX_HOLD`.
  - On release: `grant` goes to 0, the FSM returns to IDLE, and `hold_cnt` goes to 0.
  - Otherwise `hold_cnt` increments; it never exceeds `MAX_HOLD`.
- **Mandatory gap:** every GRANT→IDLE transition spends at least one cycle in IDLE with `grant` = 0, even if other requests are pending. This gives fairness and makes hand-off visible to the bench.
- **Mid-grant request changes:** requests arriving or dropping on non-owner indices while in GRANT have no effect until IDLE.
- **Reset**
  - When `rst_n` is low at an edge: FSM goes to IDLE, `grant` = 0, `o` = 0, `busy` = 0, `hold_cnt` = 0, `last_owner` = `N_REQ-1`.
  - Reset applied mid-grant aborts the grant in that same edge.

## Timing
- Request-to-grant latency is 1 cycle: `req` is sampled high in IDLE at edge t, and `grant` is valid after edge t.
- `o` lags `data[owner]` by one cycle. The first `o` value for a new grant appears one edge after `grant` rises.
- The edge where `req[owner]` is sampled low clears `grant`.
- `o` returns to 0 one edge after IDLE is entered.
- Worst-case wait for a continuously requesting index is `(N_REQ-1)*(MAX_HOLD+1)+1` cycles.
- With `MAX_HOLD` = 1, a lone persistent requester is granted every other cycle.
- Simultaneous release and new request resolve in the IDLE cycle, never in the releasing edge.

## Structure
- Package `long_name_rr_arbiter_pkg` contains:
  - `state_t` enum {IDLE, GRANT};
  - function `hold_w(max)` returning the counter width.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req`, `last_owner`.
  - Outputs: `winner` index and `any_req`.
  - Implemented by rotate, priority-encode, then unrotate.
  - Instantiated once.
- Top level holds the FSM, the `grant`/`o`/`hold_cnt` registers and `last_owner`.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with `req`=4'b1111 → `grant`=0, `o`=0, `busy`=0, `hold_cnt`=0 throughout. Then release reset → `grant`=4'b0001 one cycle after the first sampled high `rst_n`.
2. **Round-robin:** `req`=4'b1111 held steady, `MAX_HOLD`=8 → grants 0001, 0010, 0100, 1000, 0001. Each lasts 8 cycles, with one IDLE cycle between grants.
3. **Early release and data path:** grant index 2, drive `data[2]`=1,0,1 → `o`=1,0,1 one cycle later. Drop `req[2]` → `grant`=0 on that edge and `hold_cnt`=0.
4. **Sparse requests:** `req`=4'b1010 after `last_owner`=3 → index 1 granted first, then index 3. Indices 0 and 2 are never granted.
5. **Reset mid-grant:** pull `rst_n` low at `hold_cnt`=5 → the next edge gives `grant`=0, `o`=0. After reset, with all requests high, index 0 wins again.
6. **Long log message:** log the full hierarchical path of `grant` and `o` each cycle using long messages (>4096 chars) → the simulation completes with no truncation errors.
